// File: rtl/cache_line_filler_pkg.sv
// Shared line geometry and refill FSM encodings for the direct-mapped cache
// and its memory-side line filler, so both agree on how a line is laid out.
package cache_line_filler_pkg;

    localparam int ZEROS_BITWIDTH       = 2;
    localparam int COLUMN_IX_BITWIDTH   = 3;
    localparam int ADDRESS_BITWIDTH     = 32;
    localparam int WORD_BITWIDTH        = 32;
    localparam int BYTE_ENABLE_BITWIDTH = 4;
    localparam int LINE_WORDS           = 1 << COLUMN_IX_BITWIDTH;
    localparam int COUNTER_BITWIDTH     = COLUMN_IX_BITWIDTH + 1;
    localparam int LINE_OFFSET_BITWIDTH = COLUMN_IX_BITWIDTH + ZEROS_BITWIDTH;

    localparam logic [BYTE_ENABLE_BITWIDTH-1:0] WRITE_ALL_BYTES  = 4'b1111;
    localparam logic [BYTE_ENABLE_BITWIDTH-1:0] WRITE_NO_BYTES   = 4'b0000;

    typedef enum logic [1:0] {
        FILL_IDLE    = 2'd0,
        FILL_REQUEST = 2'd1,
        FILL_BURST   = 2'd2,
        FILL_DONE    = 2'd3
    } fill_state_t;

    // Clears the column index and byte offset bits, giving the line base.
    function automatic logic [ADDRESS_BITWIDTH-1:0] line_base(
        input logic [ADDRESS_BITWIDTH-1:0] address
    );
        logic [ADDRESS_BITWIDTH-1:0] mask;
        mask = {ADDRESS_BITWIDTH{1'b1}} << LINE_OFFSET_BITWIDTH;
        return address & mask;
    endfunction

endpackage

// File: rtl/cache_line_filler.sv
// Line refill engine: on a miss it fetches the aligned line from the burst
// memory and streams each accepted word into the cache write port.
module cache_line_filler
    import cache_line_filler_pkg::*;
(
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            fill_req,
    input  logic [ADDRESS_BITWIDTH-1:0]     fill_address,
    output logic                            busy,
    output logic                            done,
    output logic [ADDRESS_BITWIDTH-1:0]     mem_address,
    output logic                            mem_read_req,
    input  logic                            mem_read_ack,
    input  logic [WORD_BITWIDTH-1:0]        mem_data,
    input  logic                            mem_data_valid,
    output logic [ADDRESS_BITWIDTH-1:0]     cache_address,
    output logic [WORD_BITWIDTH-1:0]        cache_data_in,
    output logic [BYTE_ENABLE_BITWIDTH-1:0] cache_write_enable
);

    fill_state_t                     state_q, state_d;
    logic [COUNTER_BITWIDTH-1:0]     counter_q, counter_d;
    logic                            busy_q, busy_d;
    logic                            done_q, done_d;
    logic                            mem_read_req_q, mem_read_req_d;
    logic [ADDRESS_BITWIDTH-1:0]     mem_address_q, mem_address_d;
    logic [ADDRESS_BITWIDTH-1:0]     cache_address_q, cache_address_d;
    logic [WORD_BITWIDTH-1:0]        cache_data_q, cache_data_d;
    logic [BYTE_ENABLE_BITWIDTH-1:0] cache_we_q, cache_we_d;

    // mem_address doubles as the latched line base for the whole fill.
    // Next-state and next-output logic; the write strobe defaults low so it
    // is only ever a single-cycle pulse per accepted word.
    always_comb begin
        state_d         = state_q;
        counter_d       = counter_q;
        busy_d          = busy_q;
        done_d          = 1'b0;
        mem_read_req_d  = mem_read_req_q;
        mem_address_d   = mem_address_q;
        cache_address_d = cache_address_q;
        cache_data_d    = cache_data_q;
        cache_we_d      = WRITE_NO_BYTES;

        case (state_q)
            FILL_IDLE: begin
                if (fill_req) begin
                    state_d        = FILL_REQUEST;
                    busy_d         = 1'b1;
                    mem_read_req_d = 1'b1;
                    mem_address_d  = line_base(fill_address);
                end
            end
            FILL_REQUEST: begin
                if (mem_read_ack) begin
                    state_d        = FILL_BURST;
                    mem_read_req_d = 1'b0;
                    counter_d      = '0;
                end
            end
            FILL_BURST: begin
                if (mem_data_valid) begin
                    cache_address_d = mem_address_q
                                    + (ADDRESS_BITWIDTH'(counter_q) << ZEROS_BITWIDTH);
                    cache_data_d    = mem_data;
                    cache_we_d      = WRITE_ALL_BYTES;
                    counter_d       = counter_q + COUNTER_BITWIDTH'(1);
                    if (counter_q == COUNTER_BITWIDTH'(LINE_WORDS - 1)) begin
                        state_d = FILL_DONE;
                        done_d  = 1'b1;
                    end
                end
            end
            FILL_DONE: begin
                state_d = FILL_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = FILL_IDLE;
            end
        endcase
    end

    // State and registered outputs; reset abandons any fill in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= FILL_IDLE;
            counter_q       <= '0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            mem_read_req_q  <= 1'b0;
            mem_address_q   <= '0;
            cache_address_q <= '0;
            cache_data_q    <= '0;
            cache_we_q      <= WRITE_NO_BYTES;
        end else begin
            state_q         <= state_d;
            counter_q       <= counter_d;
            busy_q          <= busy_d;
            done_q          <= done_d;
            mem_read_req_q  <= mem_read_req_d;
            mem_address_q   <= mem_address_d;
            cache_address_q <= cache_address_d;
            cache_data_q    <= cache_data_d;
            cache_we_q      <= cache_we_d;
        end
    end

    assign busy               = busy_q;
    assign done               = done_q;
    assign mem_read_req       = mem_read_req_q;
    assign mem_address        = mem_address_q;
    assign cache_address      = cache_address_q;
    assign cache_data_in      = cache_data_q;
    assign cache_write_enable = cache_we_q;

endmodule

// File: tb/tb_cache_line_filler.sv
// Scoreboard bench for cache_line_filler: each fill pushes its eight expected
// cache writes, and a monitor pops and compares them as strobes appear.
module tb_cache_line_filler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fill_req;
    logic [31:0] fill_address;
    logic        busy;
    logic        done;
    logic [31:0] mem_address;
    logic        mem_read_req;
    logic        mem_read_ack;
    logic [31:0] mem_data;
    logic        mem_data_valid;
    logic [31:0] cache_address;
    logic [31:0] cache_data_in;
    logic [3:0]  cache_write_enable;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } write_t;

    write_t expected_q[$];
    write_t popped;
    int total = 0;
    int bad = 0;
    int write_count = 0;
    int done_count = 0;
    int cycle = 0;
    int last_wait = 0;
    int last_latency = 0;

    cache_line_filler dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .fill_req           (fill_req),
        .fill_address       (fill_address),
        .busy               (busy),
        .done               (done),
        .mem_address        (mem_address),
        .mem_read_req       (mem_read_req),
        .mem_read_ack       (mem_read_ack),
        .mem_data           (mem_data),
        .mem_data_valid     (mem_data_valid),
        .cache_address      (cache_address),
        .cache_data_in      (cache_data_in),
        .cache_write_enable (cache_write_enable)
    );

    // Free-running clock, 10 time units per cycle.
    always #5 clk = ~clk;

    // Cycle counter used to measure fill latency.
    always @(posedge clk) cycle++;

    // Counts one comparison and reports it when the observed value is wrong.
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
        end
    endtask

    // Monitor: every write strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (done === 1'b1) done_count++;
            if (cache_write_enable !== 4'b0000) begin
                write_count++;
                if (expected_q.size() == 0) begin
                    checkOutput("spurious_write", 32'(cache_write_enable), 32'h0);
                end else begin
                    popped = expected_q.pop_front();
                    checkOutput("write_addr", cache_address, popped.addr);
                    checkOutput("write_data", cache_data_in, popped.data);
                    checkOutput("write_enable", 32'(cache_write_enable), 32'hF);
                end
            end
        end
    end

    // Checks every output is cleared, used after reset assertion.
    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_busy"}, 32'(busy), 32'h0);
        checkOutput({tag, "_done"}, 32'(done), 32'h0);
        checkOutput({tag, "_req"}, 32'(mem_read_req), 32'h0);
        checkOutput({tag, "_mem_address"}, mem_address, 32'h0);
        checkOutput({tag, "_cache_address"}, cache_address, 32'h0);
        checkOutput({tag, "_cache_data"}, cache_data_in, 32'h0);
        checkOutput({tag, "_we"}, 32'(cache_write_enable), 32'h0);
    endtask

    // Runs one fill, acting as core and burst memory at once.
    task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] d0,
                                 input int ack_delay, input bit gapped,
                                 input bit spurious, input int abort_after,
                                 input bit hold_req, input logic [31:0] next_addr,
                                 input int busy_mid);
        logic [31:0] base;
        write_t      w;
        int          start_writes;
        int          start_dones;
        int          c0;
        int          waited;
        bit          accepted;

        base = addr & 32'hFFFF_FFE0;
        for (int i = 0; i < 8; i++) begin
            w.addr = base + 32'(4 * i);
            w.data = d0 + 32'(i);
            expected_q.push_back(w);
        end
        start_writes = write_count;
        start_dones  = done_count;

        @(posedge clk); #1;
        fill_req       = 1'b1;
        fill_address   = addr;
        c0             = cycle;
        mem_data_valid = spurious;
        mem_data       = 32'hDEAD_0000;

        waited   = 0;
        accepted = 1'b0;
        while (!accepted && waited < 20) begin
            @(negedge clk);
            if (busy === 1'b1) accepted = 1'b1;
            else waited++;
        end
        last_wait = waited;
        checkOutput("accept", 32'(accepted), 32'h1);
        if (!accepted) begin
            expected_q.delete();
            fill_req = 1'b0;
            return;
        end
        checkOutput("req_raised", 32'(mem_read_req), 32'h1);
        checkOutput("mem_address", mem_address, base);
        if (!hold_req) fill_req = 1'b0;

        for (int i = 0; i <= ack_delay; i++) begin
            if (i > 0) begin
                checkOutput("req_held", 32'(mem_read_req), 32'h1);
                checkOutput("mem_address_stable", mem_address, base);
            end
            mem_read_ack   = (i == ack_delay);
            mem_data_valid = spurious;
            @(negedge clk);
        end
        mem_read_ack   = 1'b0;
        mem_data_valid = 1'b0;
        checkOutput("req_dropped", 32'(mem_read_req), 32'h0);

        for (int wi = 0; wi < 8; wi++) begin
            if (wi == abort_after) begin
                #1 rst_n = 1'b0;
                mem_data_valid = 1'b0;
                #1 checkAllZero("reset_mid");
                expected_q.delete();
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end
            if (wi == busy_mid) begin
                fill_req     = 1'b1;
                fill_address = 32'h0000_4000;
            end
            mem_data_valid = 1'b1;
            mem_data       = d0 + 32'(wi);
            @(negedge clk);
            if (wi == busy_mid) fill_req = 1'b0;
            if (gapped && wi < 7) begin
                mem_data_valid = 1'b0;
                mem_data       = 32'hBAD0_0000 + 32'(wi);
                @(negedge clk);
            end
        end

        if (hold_req) fill_address = next_addr;
        mem_data_valid = spurious;
        mem_data       = 32'hDEAD_0009;
        last_latency   = cycle - c0 + 1;
        checkOutput("done_high", 32'(done), 32'h1);
        checkOutput("busy_in_done", 32'(busy), 32'h1);

        @(negedge clk);
        mem_data_valid = 1'b0;
        checkOutput("done_low", 32'(done), 32'h0);
        checkOutput("busy_low", 32'(busy), 32'h0);
        checkOutput("we_idle", 32'(cache_write_enable), 32'h0);
        checkOutput("write_count", 32'(write_count - start_writes), 32'd8);
        checkOutput("done_count", 32'(done_count - start_dones), 32'd1);
        checkOutput("queue_empty", 32'(expected_q.size()), 32'h0);
    endtask

    // Watchdog so a stuck DUT still ends the run.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Test sequence.
    initial begin
        rst_n          = 1'b0;
        fill_req       = 1'b0;
        fill_address   = 32'h0;
        mem_read_ack   = 1'b0;
        mem_data       = 32'h0;
        mem_data_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkAllZero("reset");
        rst_n = 1'b1;

        $display("[TB] basic fill");
        applyStimulus(32'h0000_1234, 32'hA0, 0, 1'b0, 1'b0, -1, 1'b0, 32'h0, -1);
        checkOutput("basic_accept_wait", 32'(last_wait), 32'd1);
        checkOutput("basic_latency", 32'(last_latency), 32'd11);

        $display("[TB] delayed ack, gapped data");
        applyStimulus(32'h0000_2468, 32'hB0, 5, 1'b1, 1'b0, -1, 1'b0, 32'h0, -1);

        $display("[TB] spurious data");
        applyStimulus(32'h0000_3010, 32'hC0, 1, 1'b0, 1'b1, -1, 1'b0, 32'h0, -1);

        $display("[TB] request while busy");
        applyStimulus(32'h0000_1234, 32'hD0, 0, 1'b0, 1'b0, -1, 1'b0, 32'h0, 2);
        applyStimulus(32'h0000_4000, 32'hE0, 0, 1'b0, 1'b0, -1, 1'b0, 32'h0, -1);
        checkOutput("refill_4000_wait", 32'(last_wait), 32'd1);

        $display("[TB] reset mid burst");
        applyStimulus(32'h0000_1234, 32'h10, 0, 1'b0, 1'b0, 3, 1'b0, 32'h0, -1);
        applyStimulus(32'h0000_1234, 32'h20, 0, 1'b0, 1'b0, -1, 1'b0, 32'h0, -1);

        $display("[TB] back-to-back fills");
        applyStimulus(32'h0000_5678, 32'h30, 0, 1'b0, 1'b0, -1, 1'b1, 32'h0000_6004, -1);
        applyStimulus(32'h0000_6004, 32'h40, 0, 1'b0, 1'b0, -1, 1'b0, 32'h0, -1);
        checkOutput("b2b_accept_wait", 32'(last_wait), 32'd0);

        repeat (3) @(negedge clk);
        checkOutput("final_queue_empty", 32'(expected_q.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
